// File: rtl/boot_ctrl.sv
// boot_ctrl: CPU boot sequencer -- PC load pulse, settle delay, run window and done report.
// Optional run watchdog is built when BOOT_CTRL_WATCHDOG_EN is defined.
module boot_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h00400020,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] MAX_CYCLES  = 32'd1250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  output logic        pc_ld,
  output logic [31:0] pc_data,
  output logic        clockthing,
  output logic        done,
  output logic        timeout,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, DONE} state_t;

  localparam logic [7:0] SETTLE_LD = 8'(WAIT_CYCLES);

  state_t      state;
  logic [7:0]  settle_cnt;
  logic [31:0] count_nxt;
  logic        limit_hit;

  if (WAIT_CYCLES > 255) begin : g_bad_wait
    $error("boot_ctrl: WAIT_CYCLES must be 0..255");
  end
  if (MAX_CYCLES == 32'd0) begin : g_bad_max
    $error("boot_ctrl: MAX_CYCLES must be at least 1");
  end

  assign count_nxt = cycle_count + 32'd1;

`ifdef BOOT_CTRL_WATCHDOG_EN
  // halt takes precedence, so the limit only counts when halt is low
  assign limit_hit = (state == RUN) && !halt && (count_nxt == MAX_CYCLES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout <= 1'b0;
    end else if ((state == IDLE || state == DONE) && start) begin
      timeout <= 1'b0;
    end else if (limit_hit) begin
      timeout <= 1'b1;
    end
  end
`else
  assign limit_hit = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      pc_ld       <= 1'b0;
      pc_data     <= RESET_PC;
      clockthing  <= 1'b0;
      done        <= 1'b0;
      cycle_count <= '0;
    end else begin
      pc_data <= RESET_PC;
      pc_ld   <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= LOAD;
            pc_ld       <= 1'b1;
            done        <= 1'b0;
            cycle_count <= '0;
            settle_cnt  <= SETTLE_LD;
          end
        end
        LOAD: begin
          if (WAIT_CYCLES == 0) begin
            state      <= RUN;
            clockthing <= 1'b1;
          end else begin
            state <= SETTLE;
          end
        end
        SETTLE: begin
          // counter holds the remaining settle cycles including the current one
          settle_cnt <= settle_cnt - 8'd1;
          if (settle_cnt == 8'd1) begin
            state      <= RUN;
            clockthing <= 1'b1;
          end
        end
        RUN: begin
          cycle_count <= count_nxt;
          if (halt || limit_hit) begin
            state      <= DONE;
            clockthing <= 1'b0;
            done       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_ctrl.sv
// tb_boot_ctrl: vector-table and scoreboard bench for boot_ctrl (default and WAIT_CYCLES=0/MAX_CYCLES=10 instances).
module tb_boot_ctrl;

`ifdef BOOT_CTRL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  localparam logic [31:0] PC_EXP = 32'h00400020;

  logic clk = 1'b0;
  logic reset;
  logic start_a, halt_a, start_b, halt_b;
  logic pc_ld_a, ct_a, done_a, to_a;
  logic pc_ld_b, ct_b, done_b, to_b;
  logic [31:0] pcd_a, cc_a, pcd_b, cc_b;

  always #5 clk = ~clk;

  boot_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start_a), .halt(halt_a),
    .pc_ld(pc_ld_a), .pc_data(pcd_a), .clockthing(ct_a),
    .done(done_a), .timeout(to_a), .cycle_count(cc_a)
  );

  boot_ctrl #(.WAIT_CYCLES(0), .MAX_CYCLES(32'd10)) u_fast (
    .clk(clk), .reset(reset), .start(start_b), .halt(halt_b),
    .pc_ld(pc_ld_b), .pc_data(pcd_b), .clockthing(ct_b),
    .done(done_b), .timeout(to_b), .cycle_count(cc_b)
  );

  typedef struct {
    bit          sel;
    bit          start;
    bit          halt;
    bit          pc_ld;
    bit          ct;
    bit          done;
    bit          to;
    logic [31:0] cc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned step  = 0;

  function automatic vec_t mk(input bit sel, input bit st, input bit hl, input bit pl,
                              input bit ct, input bit dn, input bit to, input logic [31:0] cc);
    vec_t v;
    v.sel = sel; v.start = st; v.halt = hl; v.pc_ld = pl;
    v.ct = ct; v.done = dn; v.to = to; v.cc = cc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input vec_t e, input string tag);
    if (!e.sel) begin
      chk({tag, ".pc_ld"},       32'(pc_ld_a), 32'(e.pc_ld));
      chk({tag, ".pc_data"},     pcd_a,        PC_EXP);
      chk({tag, ".clockthing"},  32'(ct_a),    32'(e.ct));
      chk({tag, ".done"},        32'(done_a),  32'(e.done));
      chk({tag, ".timeout"},     32'(to_a),    32'(e.to));
      chk({tag, ".cycle_count"}, cc_a,         e.cc);
    end else begin
      chk({tag, ".pc_ld"},       32'(pc_ld_b), 32'(e.pc_ld));
      chk({tag, ".pc_data"},     pcd_b,        PC_EXP);
      chk({tag, ".clockthing"},  32'(ct_b),    32'(e.ct));
      chk({tag, ".done"},        32'(done_b),  32'(e.done));
      chk({tag, ".timeout"},     32'(to_b),    32'(e.to));
      chk({tag, ".cycle_count"}, cc_b,         e.cc);
    end
  endtask

  // drive one cycle of stimulus, queue its expectation, check after the edge
  task automatic cyc(input vec_t v);
    vec_t e;
    start_a = v.sel ? 1'b0 : v.start;
    halt_a  = v.sel ? 1'b0 : v.halt;
    start_b = v.sel ? v.start : 1'b0;
    halt_b  = v.sel ? v.halt : 1'b0;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_out(e, $sformatf("%s_step%0d", e.sel ? "fast" : "dflt", step));
    step++;
  endtask

  task automatic check_reset_vals(input string tag);
    vec_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 32'd0);
    check_out(z, {tag, "_dflt"});
    z.sel = 1'b1;
    check_out(z, {tag, "_fast"});
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0; halt_a = 1'b0; start_b = 1'b0; halt_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;

    // default instance: boot, 40-cycle run ended by halt, hold, restart from DONE
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 1; k <= 39; k++)
      tbl.push_back(mk(0, (k == 7), 0, 0, 1, 0, 0, 32'(k)));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 40));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 40));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1));

    // WAIT_CYCLES=0 instance: run enable right after LOAD, watchdog at 10
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 1; k <= 9; k++)
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 32'(k)));
    if (WD) begin
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 10));
      tbl.push_back(mk(1, 0, 1, 0, 0, 1, 1, 10));
    end else begin
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 10));
      tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 11));
    end
    // restart clears timeout; halt on the 10th edge beats the watchdog
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 1; k <= 9; k++)
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 32'(k)));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 10));

    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i]);

    // asynchronous reset in the middle of RUN, then a full repeat sequence
    cyc(mk(0, 1, 0, 1, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 1; k <= 5; k++)
      cyc(mk(0, 0, 0, 0, 1, 0, 0, 32'(k)));
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async_reset");
    @(posedge clk);
    #1;
    check_reset_vals("held_reset");
    reset = 1'b0;
    cyc(mk(0, 1, 0, 1, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 1));
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 2));
    cyc(mk(0, 0, 1, 0, 0, 1, 0, 3));
    cyc(mk(0, 0, 0, 0, 0, 1, 0, 3));

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
